dequant: RTL
============

Name: dequant

Overview:
- Inverse of the ACO quantizer. Takes a signed 8b stream, sign-extends it and left-shifts it by a configurable amount to rebuild a signed 16b stream, saturating at the 16b limits.
- Sits between the 8b feature/weight path and any 16b consumer: loopback checking of the quantizer, and re-expansion before accumulation.
- Adds ready/valid backpressure through a 2-entry output buffer.
- Applies shift updates only at frame boundaries.
- Counts saturation events.

Parameters:
- I_BW, 8, input sample width (signed).
- O_BW, 16, output sample width (signed).
- SHIFT_BW, 4, shift amount width; the shift range is 0..15.
- CNT_BW, 16, saturation counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  block enable; when low, accepted beats are discarded.
- shift_i  in  SHIFT_BW  new left-shift amount.
- wr_en  in  1  writes shift_i into the pending shift register.
- sat_clr_i  in  1  synchronous clear of the saturation counter.
- data_i  in  I_BW  signed input sample.
- valid_i  in  1  input beat valid.
- last_i  in  1  input beat is the last of its frame.
- ready_o  out  1  block can accept a beat.
- data_o  out  O_BW  signed output sample.
- valid_o  out  1  output beat valid.
- last_o  out  1  output frame marker.
- ready_i  in  1  downstream accepts the output beat.
- sat_cnt_o  out  CNT_BW  number of saturated beats, sticky at maximum.

Behaviour:
- Reset (asynchronous, active-high):
  - Buffer is emptied.
  - valid_o=0, last_o=0, data_o=0.
  - shift_pending=0, shift_active=0, in_frame=0, sat_cnt_o=0.
  - ready_o=0 while rst_i is high; ready_o=1 on the first cycle after release.
- Handshakes:
  - Input accept = valid_i & ready_o.
  - Output transfer = valid_o & ready_i.
  - ready_o = (buffer count < 2); there is no combinational path from ready_i.
- Latency: 1 cycle from accept to valid_o when the buffer is empty.
- Ordering: FIFO order is preserved; last_o travels with its data.
- Buffer count:
  - Accept and transfer in the same cycle: count is unchanged.
  - Accept with count==2 is impossible, because ready_o=0.
  - Transfer with count==0 is impossible, because valid_o=0.
- Arithmetic:
  - x = sign-extend(data_i) to 24b; p = x <<< shift_active.
  - If p > 32767, output 0x7FFF and flag saturation.
  - If p < -32768, output 0x8000 and flag saturation.
  - Otherwise output p[15:0].
  - The value -32768 exactly is not a saturation.
- en_i:
  - When en_i=0, accepted beats are dropped.
  - Dropped beats do not enter the buffer, do not affect in_frame, and do not count toward saturation.
- Shift update:
  - wr_en at cycle t: shift_pending <= shift_i, visible at t+1.
  - shift_active <= shift_pending on every cycle where in_frame_next==0.
  - in_frame_next: set by an enabled accepted beat with last_i=0; cleared by an enabled accepted beat with last_i=1.
  - A beat always uses the shift_active value held in its accept cycle.
  - Result: shift changes never take effect mid-frame. With no frame in progress, the earliest effect is 2 cycles after wr_en.
  - Back-to-back wr_en: the last write before the frame boundary wins.
- Saturation counter:
  - Increments by 1 per enabled accepted saturated beat.
  - Sticks at 2^CNT_BW-1.
  - sat_clr_i together with a saturated beat: counter becomes 1.
- Reset mid-frame: buffered beats are lost, in_frame clears, and the next accepted beat starts a new frame.

Decomposition:
- Package dequant_pkg holds I_BW, O_BW, SHIFT_BW, CNT_BW, SAT_MAX=16'sh7FFF and SAT_MIN=16'sh8000.
- Sub-module dequant_fifo2: a 2-entry {last, data} buffer with count, push/pop and asynchronous reset. It owns valid_o and ready_o.
- The top level holds the shift pending/active registers, frame tracking, saturating arithmetic and the counter.

Test Plan:
- Basic scaling: shift=4 written between frames; beat 0x05 with last=1 -> data_o=0x0050 and last_o=1 one cycle later; beat 0xFB -> 0xFFB0; sat_cnt_o=0.
- Saturation: shift=10; beats 0x7F then 0x80 -> 0x7FFF then 0x8000; sat_cnt_o=2; pulse sat_clr_i -> 0; sat_clr_i with a saturating beat -> 1.
- Boundary: shift=15; beat 0xFF (-1) -> 0x8000 with no saturation counted; beat 0x01 -> 0x7FFF with sat_cnt_o incremented.
- Backpressure: ready_i=0; offer 3 beats A,B,C -> A and B accepted, ready_o=0 after B, C held. Then ready_i=1 -> A,B,C emerge in order with no duplication.
- Frame-boundary shift: shift=2; 4-beat frame of 0x03; wr_en shift=5 during beat 2 -> all four outputs 0x000C. Next frame's beat 0x03 -> 0x0060.
- Reset mid-frame and enable: 2 beats buffered, assert rst_i -> valid_o=0 immediately, sat_cnt_o=0. Then en_i=0 with 3 beats -> no output and ready_o stays 1.

Source files
------------

// File: rtl/dequant_pkg.sv
// rtl/dequant_pkg.sv - shared widths and saturation limits for the dequantizer
package dequant_pkg;

    localparam int I_BW     = 8;
    localparam int O_BW     = 16;
    localparam int SHIFT_BW = 4;
    localparam int CNT_BW   = 16;

    // Widest shifted value: 8b input shifted by up to 15 fits in 24b signed.
    localparam int XW = 24;

    localparam logic signed [O_BW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [O_BW-1:0] SAT_MIN = 16'sh8000;

    localparam logic [CNT_BW-1:0] CNT_MAX = {CNT_BW{1'b1}};

endpackage

// File: rtl/dequant_fifo2.sv
// rtl/dequant_fifo2.sv - two-entry {last, data} output buffer with registered head
module dequant_fifo2
    import dequant_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            push_last,
    input  logic [O_BW-1:0] push_data,
    input  logic            pop,
    output logic            valid,
    output logic            ready,
    output logic            last,
    output logic [O_BW-1:0] data
);

    logic [1:0]      count;
    logic [O_BW-1:0] tail_data;
    logic            tail_last;
    logic            live;
    logic            push_ok;
    logic            pop_ok;

    // live holds ready low for as long as reset is asserted
    assign valid   = (count != 2'd0);
    assign ready   = live && (count != 2'd2);
    assign push_ok = push && ready;
    assign pop_ok  = pop && valid;

    // head entry drives the outputs directly; tail only fills when head is busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            data      <= '0;
            last      <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            if (pop_ok && count == 2'd2) begin
                data <= tail_data;
                last <= tail_last;
            end
            if (push_ok) begin
                if (count == 2'd0 || (count == 2'd1 && pop_ok)) begin
                    data <= push_data;
                    last <= push_last;
                end else begin
                    tail_data <= push_data;
                    tail_last <= push_last;
                end
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/dequant.sv
// rtl/dequant.sv - sign-extend, left-shift and saturate an 8b stream to 16b
module dequant
    import dequant_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [SHIFT_BW-1:0] shift_i,
    input  logic                wr_en,
    input  logic                sat_clr_i,
    input  logic [I_BW-1:0]     data_i,
    input  logic                valid_i,
    input  logic                last_i,
    output logic                ready_o,
    output logic [O_BW-1:0]     data_o,
    output logic                valid_o,
    output logic                last_o,
    input  logic                ready_i,
    output logic [CNT_BW-1:0]   sat_cnt_o
);

    logic [SHIFT_BW-1:0] shift_pending;
    logic [SHIFT_BW-1:0] shift_active;
    logic                in_frame;
    logic                in_frame_next;
    logic                accept_en;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] p;
    logic                sat_hi;
    logic                sat_lo;
    logic                sat_beat;
    logic [O_BW-1:0]     result;

    // Dropped beats (en_i low) still handshake but never reach the buffer.
    assign accept_en = valid_i && ready_o && en_i;

    assign x      = {{(XW-I_BW){data_i[I_BW-1]}}, data_i};
    assign p      = x <<< shift_active;
    assign sat_hi = (p > 24'sd32767);
    assign sat_lo = (p < -24'sd32768);
    assign sat_beat = accept_en && (sat_hi || sat_lo);

    // clamp to the 16b range; -32768 exactly passes through unflagged
    always_comb begin
        result = p[O_BW-1:0];
        if (sat_hi) begin
            result = SAT_MAX;
        end else if (sat_lo) begin
            result = SAT_MIN;
        end
    end

    assign in_frame_next = accept_en ? !last_i : in_frame;

    // Shift register pair: the active value only follows pending between frames.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_pending <= '0;
            shift_active  <= '0;
            in_frame      <= 1'b0;
        end else begin
            if (wr_en) begin
                shift_pending <= shift_i;
            end
            if (!in_frame_next) begin
                shift_active <= shift_pending;
            end
            in_frame <= in_frame_next;
        end
    end

    // saturation counter: clear wins over count, but a saturated beat in the clear cycle counts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_cnt_o <= '0;
        end else if (sat_clr_i) begin
            sat_cnt_o <= sat_beat ? {{(CNT_BW-1){1'b0}}, 1'b1} : '0;
        end else if (sat_beat && sat_cnt_o != CNT_MAX) begin
            sat_cnt_o <= sat_cnt_o + 1'b1;
        end
    end

    dequant_fifo2 u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (accept_en),
        .push_last (last_i),
        .push_data (result),
        .pop       (ready_i),
        .valid     (valid_o),
        .ready     (ready_o),
        .last      (last_o),
        .data      (data_o)
    );

endmodule
